// File: rtl/voice_pkg.sv
// voice_pkg: shared types and constants for the voice matcher.
//   dir_t   - 2-bit match code reported for the closest template
//   state_t - control states of the compare scheduler
//   VOICE_ADDR_W / VOICE_DATA_W - default sample-RAM geometry
package voice_pkg;

    localparam int VOICE_ADDR_W = 12;
    localparam int VOICE_DATA_W = 32;
    localparam int NUM_TMPL     = 4;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DRAIN, ST_DECIDE} state_t;

endpackage

// File: rtl/popcount_word.sv
// popcount_word: combinational count of set bits in one RAM word.
// Ports:
//   word  in  DATA_W  word to count
//   count out CNT_W   number of '1' bits in word
module popcount_word #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] word,
    output logic [CNT_W-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < DATA_W; i++) begin
            count = count + CNT_W'(word[i]);
        end
    end

endmodule

// File: rtl/voice_match_sched.sv
// voice_match_sched: owns the shared address bus of the live sample RAM and
// the four template RAMs. In IDLE the recorder drives the bus directly; on
// start the scheduler sweeps all DEPTH words, accumulates the Hamming
// distance of each template against the live recording and reports the
// closest template. Recorder requests abort a running compare.
//
// Optional feature: define VOICE_MATCH_REJECT_EN to flag results whose
// winning distance exceeds REJECT_THRESH on no_match. Without the macro
// no_match is tied to 0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 single-cycle compare request
//   rec_req/rec_addr/rec_wr  recorder bus request, address, write strobe
//   rec_gnt               bus granted to recorder
//   ram_addr, ram_wr      shared RAM address and gated write strobe
//   live_dout, up/down/left/right_dout  RAM read data (1-cycle latency)
//   busy                  compare in progress
//   match, min_dist       closest template and its distance
//   match_valid, aborted  one-cycle result / abort pulses
//   no_match              threshold reject flag
module voice_match_sched
    import voice_pkg::*;
#(
    parameter int          ADDR_W        = VOICE_ADDR_W,
    parameter int          DEPTH         = 4096,
    parameter int          DATA_W        = VOICE_DATA_W,
    parameter int          ACC_W         = 18,
    parameter int unsigned REJECT_THRESH = 20000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rec_req,
    input  logic [ADDR_W-1:0] rec_addr,
    input  logic              rec_wr,
    output logic              rec_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    input  logic [DATA_W-1:0] live_dout,
    input  logic [DATA_W-1:0] up_dout,
    input  logic [DATA_W-1:0] down_dout,
    input  logic [DATA_W-1:0] left_dout,
    input  logic [DATA_W-1:0] right_dout,
    output logic              busy,
    output logic [1:0]        match,
    output logic [ACC_W-1:0]  min_dist,
    output logic              match_valid,
    output logic              aborted,
    output logic              no_match
);

    localparam int              CNT_W     = $clog2(DATA_W + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (DEPTH < 2 || 64'(DEPTH) > (64'(1) << ADDR_W)) begin : g_bad_depth
        $error("DEPTH must lie in 2 .. 2**ADDR_W");
    end
    if (ACC_W < ADDR_W + 6) begin : g_bad_acc
        $error("ACC_W must be at least ADDR_W+6");
    end
    if (64'(REJECT_THRESH) >= (64'(1) << ACC_W)) begin : g_bad_thresh
        $error("REJECT_THRESH does not fit in ACC_W bits");
    end

    state_t              state;
    logic [ADDR_W-1:0]   sweep_addr;
    logic                rd_vld;
    logic [ACC_W-1:0]    acc [NUM_TMPL];

    logic [DATA_W-1:0]   tmpl_dout [NUM_TMPL];
    logic [DATA_W-1:0]   diff_p1   [NUM_TMPL];
    logic [CNT_W-1:0]    cnt_p1    [NUM_TMPL];

    dir_t                best_idx;
    logic [ACC_W-1:0]    best_dist;

    assign tmpl_dout[0] = up_dout;
    assign tmpl_dout[1] = down_dout;
    assign tmpl_dout[2] = left_dout;
    assign tmpl_dout[3] = right_dout;

    // ---- stage p1: RAM data returned, per-template bit distance ----
    for (genvar g = 0; g < NUM_TMPL; g++) begin : g_pc
        assign diff_p1[g] = live_dout ^ tmpl_dout[g];

        popcount_word #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_popcount (
            .word  (diff_p1[g]),
            .count (cnt_p1[g])
        );
    end

    // ---- decide: strict less-than keeps the lowest index on ties ----
    always_comb begin
        best_idx  = DIR_UP;
        best_dist = acc[0];
        for (int i = 1; i < NUM_TMPL; i++) begin
            if (acc[i] < best_dist) begin
                best_idx  = dir_t'(2'(i));
                best_dist = acc[i];
            end
        end
    end

    // Bus mux: recorder owns the bus only while idle.
    always_comb begin
        rec_gnt  = 1'b0;
        ram_wr   = 1'b0;
        ram_addr = sweep_addr;
        if (state == ST_IDLE) begin
            rec_gnt  = rec_req;
            ram_addr = rec_addr;
            ram_wr   = rec_wr & rec_req;
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sweep_addr  <= '0;
            rd_vld      <= 1'b0;
            for (int i = 0; i < NUM_TMPL; i++) acc[i] <= '0;
            match       <= DIR_UP;
            min_dist    <= '0;
            match_valid <= 1'b0;
            aborted     <= 1'b0;
`ifdef VOICE_MATCH_REJECT_EN
            no_match    <= 1'b0;
`endif
        end else begin
            match_valid <= 1'b0;
            aborted     <= 1'b0;

            // ---- stage p2: accumulate the word read in the previous cycle ----
            if (rd_vld) begin
                for (int i = 0; i < NUM_TMPL; i++) begin
                    acc[i] <= acc[i] + {{(ACC_W - CNT_W){1'b0}}, cnt_p1[i]};
                end
            end

            case (state)
                ST_IDLE: begin
                    rd_vld <= 1'b0;
                    if (start && !rec_req) begin
                        state      <= ST_SWEEP;
                        sweep_addr <= '0;
                        for (int i = 0; i < NUM_TMPL; i++) acc[i] <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (rec_req) begin
                        state   <= ST_IDLE;
                        rd_vld  <= 1'b0;
                        aborted <= 1'b1;
                    end else begin
                        rd_vld     <= 1'b1;
                        sweep_addr <= sweep_addr + 1'b1;
                        if (sweep_addr == LAST_ADDR) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    rd_vld <= 1'b0;
                    if (rec_req) begin
                        state   <= ST_IDLE;
                        aborted <= 1'b1;
                    end else begin
                        state <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    rd_vld <= 1'b0;
                    state  <= ST_IDLE;
                    if (rec_req) begin
                        aborted <= 1'b1;
                    end else begin
                        match       <= best_idx;
                        min_dist    <= best_dist;
                        match_valid <= 1'b1;
`ifdef VOICE_MATCH_REJECT_EN
                        no_match    <= (best_dist > ACC_W'(REJECT_THRESH));
`endif
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    rd_vld <= 1'b0;
                end
            endcase
        end
    end

`ifndef VOICE_MATCH_REJECT_EN
    assign no_match = 1'b0;
`endif

endmodule

// File: tb/tb_voice_match_sched.sv
// Bench for voice_match_sched with DEPTH=16. Holds the five RAMs as arrays,
// predicts each compare result from whole-array Hamming distances, and
// tracks the expected output timeline of every compare.
module tb_voice_match_sched;
    import voice_pkg::*;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 18;
    localparam int THRESH = 100;
`ifdef VOICE_MATCH_REJECT_EN
    localparam bit REJ = 1'b1;
`else
    localparam bit REJ = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, rec_req, rec_wr;
    logic [ADDR_W-1:0] rec_addr;
    logic              rec_gnt, ram_wr, busy, match_valid, aborted, no_match;
    logic [ADDR_W-1:0] ram_addr;
    logic [1:0]        match;
    logic [ACC_W-1:0]  min_dist;
    logic [DATA_W-1:0] live_dout, up_dout, down_dout, left_dout, right_dout;

    // mem[0] = live, mem[1..4] = up, down, left, right
    logic [DATA_W-1:0] mem [5][DEPTH];

    voice_match_sched #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .ACC_W(ACC_W),
        .REJECT_THRESH(THRESH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rec_req(rec_req),
        .rec_addr(rec_addr), .rec_wr(rec_wr), .rec_gnt(rec_gnt),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .live_dout(live_dout),
        .up_dout(up_dout), .down_dout(down_dout), .left_dout(left_dout),
        .right_dout(right_dout), .busy(busy), .match(match),
        .min_dist(min_dist), .match_valid(match_valid), .aborted(aborted),
        .no_match(no_match)
    );

    always @(posedge clk) begin
        live_dout  <= mem[0][ram_addr[3:0]];
        up_dout    <= mem[1][ram_addr[3:0]];
        down_dout  <= mem[2][ram_addr[3:0]];
        left_dout  <= mem[3][ram_addr[3:0]];
        right_dout <= mem[4][ram_addr[3:0]];
    end

    int n_cmp = 0;
    int n_fail = 0;
    int mv_count = 0;
    int ab_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: closest template by total Hamming distance, lowest index on ties.
    function automatic void predict(output logic [1:0] bi, output logic [ACC_W-1:0] bd);
        int d [4];
        int best;
        for (int t = 0; t < 4; t++) begin
            d[t] = 0;
            for (int w = 0; w < DEPTH; w++) d[t] += $countones(mem[0][w] ^ mem[t+1][w]);
        end
        best = 0;
        for (int t = 1; t < 4; t++) if (d[t] < d[best]) best = t;
        bi = 2'(best);
        bd = ACC_W'(d[best]);
    endfunction

    // Timeline model: a compare accepted at edge s occupies cycles s..s+DEPTH+1
    // and reports in the cycle after edge s+DEPTH+2, unless rec_req cuts it short.
    bit               armed = 0;
    bit               m_active = 0;
    int               m_k = 0;
    logic [1:0]       r_match;
    logic [ACC_W-1:0] r_min;
    logic [1:0]       e_match = '0;
    logic [ACC_W-1:0] e_min = '0;
    logic             e_nm = 0, e_mv = 0, e_ab = 0;

    always @(posedge clk) begin
        e_mv = 0;
        e_ab = 0;
        if (rst) begin
            armed = 1; m_active = 0; e_match = '0; e_min = '0; e_nm = 0;
        end else if (armed) begin
            if (m_active) begin
                if (rec_req) begin
                    m_active = 0; e_ab = 1;
                end else if (m_k == DEPTH + 1) begin
                    m_active = 0; e_mv = 1;
                    e_match = r_match; e_min = r_min;
                    e_nm = REJ && (r_min > ACC_W'(THRESH));
                end else begin
                    m_k++;
                end
            end else if (start && !rec_req) begin
                m_active = 1; m_k = 0;
                predict(r_match, r_min);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (match_valid === 1'b1) mv_count++;
            if (aborted === 1'b1) ab_count++;
            check("busy", busy, m_active);
            check("match_valid", match_valid, e_mv);
            check("aborted", aborted, e_ab);
            check("match", match, e_match);
            check("min_dist", min_dist, e_min);
            check("no_match", no_match, e_nm);
            if (!m_active) begin
                check("rec_gnt_idle", rec_gnt, rec_req);
                check("ram_addr_idle", ram_addr, rec_addr);
                check("ram_wr_idle", ram_wr, rec_wr & rec_req);
            end else begin
                check("rec_gnt_busy", rec_gnt, 0);
                check("ram_wr_busy", ram_wr, 0);
                if (m_k < DEPTH) check("ram_addr_sweep", ram_addr, m_k);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic run_compare(output int lat);
        start = 1; tick(); start = 0;
        lat = -1;
        for (int k = 1; k <= DEPTH + 10; k++) begin
            tick(); #1;
            if (match_valid === 1'b1) begin lat = k; break; end
        end
    endtask

    task automatic load_random();
        int a, b;
        for (int w = 0; w < DEPTH; w++) begin
            mem[0][w] = $urandom;
            for (int t = 1; t < 5; t++) mem[t][w] = mem[0][w] ^ ($urandom & $urandom & $urandom);
        end
        if ($urandom_range(0, 2) == 0) begin
            a = $urandom_range(1, 4);
            b = $urandom_range(1, 4);
            for (int w = 0; w < DEPTH; w++) mem[b][w] = mem[a][w];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, mv0, ab0;
        rst = 1; start = 0; rec_req = 0; rec_wr = 0; rec_addr = '0;
        for (int t = 0; t < 5; t++) for (int w = 0; w < DEPTH; w++) mem[t][w] = '0;
        tick(); tick();
        rst = 0;
        #1;
        check("reset_match", match, 0);
        check("reset_min_dist", min_dist, 0);
        check("reset_busy", busy, 0);
        check("reset_no_match", no_match, 0);

        // Identical templates except down: tie among up/left/right -> up.
        for (int w = 0; w < DEPTH; w++) begin
            mem[0][w] = $urandom;
            mem[1][w] = mem[0][w]; mem[2][w] = mem[0][w] ^ 32'h1;
            mem[3][w] = mem[0][w]; mem[4][w] = mem[0][w];
        end
        run_compare(lat);
        check("t1_latency", lat, 18);
        check("t1_match", match, 0);
        check("t1_min_dist", min_dist, 0);

        // Live all ones: down is closest at 16 bits/word.
        for (int w = 0; w < DEPTH; w++) begin
            mem[0][w] = 32'hFFFF_FFFF; mem[1][w] = 32'h0;
            mem[2][w] = 32'h0000_FFFF; mem[3][w] = 32'h0000_00FF; mem[4][w] = 32'h0;
        end
        tick();
        run_compare(lat);
        check("t2_latency", lat, 18);
        check("t2_match", match, 1);
        check("t2_min_dist", min_dist, 256);
        check("t2_no_match", no_match, REJ ? 1 : 0);

        // Left and right tie at 40, up/down at 512 -> left.
        for (int w = 0; w < DEPTH; w++) begin
            mem[0][w] = 32'hFFFF_FFFF; mem[1][w] = 32'h0; mem[2][w] = 32'h0;
            mem[3][w] = (w < 5) ? 32'hFFFF_FF00 : 32'hFFFF_FFFF;
            mem[4][w] = mem[3][w];
        end
        tick();
        run_compare(lat);
        check("t3_match", match, 2);
        check("t3_min_dist", min_dist, 40);
        check("t3_no_match", no_match, 0);

        // Abort on the 5th sweep cycle.
        tick();
        mv0 = mv_count; ab0 = ab_count;
        start = 1; tick(); start = 0;
        tick(); tick(); tick(); tick();
        rec_req = 1; rec_addr = 12'h123; rec_wr = 1;
        tick(); #1;
        check("t4_aborted", aborted, 1);
        check("t4_busy", busy, 0);
        check("t4_rec_gnt", rec_gnt, 1);
        check("t4_ram_addr", ram_addr, 12'h123);
        check("t4_ram_wr", ram_wr, 1);
        tick(); #1;
        check("t4_rec_gnt_next", rec_gnt, 1);
        rec_wr = 0;
        #1;
        check("t4_ram_wr_follow", ram_wr, 0);
        rec_req = 0;
        for (int k = 0; k < DEPTH + 4; k++) tick();
        check("t4_no_mv", mv_count - mv0, 0);
        check("t4_one_abort", ab_count - ab0, 1);
        check("t4_match_kept", match, 2);
        check("t4_min_kept", min_dist, 40);

        // start with rec_req high ignored; start during sweep ignored.
        rec_req = 1; start = 1; tick(); start = 0; rec_req = 0; #1;
        check("t5_ignored", busy, 0);
        mv0 = mv_count;
        tick();
        start = 1; tick(); start = 0;
        tick(); tick();
        start = 1; tick(); start = 0;
        for (int k = 0; k < 30; k++) tick();
        check("t5_one_mv", mv_count - mv0, 1);

        // rst mid-sweep: no pulses, results cleared.
        mv0 = mv_count; ab0 = ab_count;
        start = 1; tick(); start = 0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1; tick(); rst = 0; #1;
        check("t6_rst_match", match, 0);
        check("t6_rst_min", min_dist, 0);
        check("t6_rst_busy", busy, 0);
        for (int k = 0; k < DEPTH + 6; k++) tick();
        check("t6_no_mv", mv_count - mv0, 0);
        check("t6_no_abort", ab_count - ab0, 0);

        // Randomized compares with random recorder traffic and stray starts.
        for (int it = 0; it < 40; it++) begin
            load_random();
            rec_req = 0; start = 1; rec_addr = 12'($urandom); rec_wr = 1'($urandom);
            for (int c = 0; c < DEPTH + 8; c++) begin
                tick();
                start    = ($urandom_range(0, 19) == 0);
                rec_req  = m_active ? ($urandom_range(0, 79) == 0) : 1'($urandom_range(0, 1));
                rec_addr = 12'($urandom);
                rec_wr   = 1'($urandom);
            end
            start = 0; rec_req = 0;
            for (int c = 0; c < 2 * DEPTH; c++) begin
                if (busy === 1'b0 && !m_active) break;
                tick();
            end
            tick();
            check("rand_idle_reached", busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
